// File: rtl/m6809e_clkgen.sv
// m6809e_clkgen: 6809E E/Q quadrature clock generator with I/O stretch and CPU reset sequencer.
module m6809e_clkgen #(
    parameter int DIV        = 4,
    parameter int IO_WAIT    = 2,
    parameter int RST_CYCLES = 8
) (
    input  logic       hsclk,
    input  logic       rst,
    input  logic       csio_b,
    output logic       eclk,
    output logic       qclk,
    output logic [1:0] phase,
    output logic       stretching,
    output logic       cpu_rst_b
);
    localparam int QW = DIV > 1 ? $clog2(DIV) : 1;
    logic [QW-1:0] quarter_q, quarter_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    wait_q, wait_d;
    logic [7:0]    ecyc_q, ecyc_d;
    logic          eclk_q, qclk_q, stretch_q, stretch_d, rstb_q, rstb_d;
    logic          adv, hold, e_end;
    always_comb begin
        adv       = quarter_q == QW'(DIV - 1);
        quarter_d = adv ? '0 : quarter_q + 1'b1;
        hold      = phase_q == 2'd3 && wait_q != 3'd0;
        phase_d   = adv && !hold ? phase_q + 1'b1 : phase_q;
        e_end     = adv && phase_q == 2'd3 && !hold;
        // csio_b only matters on the phase 1->2 advance, and only once the CPU is out of reset
        wait_d    = !adv ? wait_q
                  : phase_q == 2'd1 ? (!csio_b && rstb_q ? 3'(IO_WAIT) : 3'd0)
                  : hold ? wait_q - 1'b1 : wait_q;
        stretch_d = adv ? hold : stretch_q;
        ecyc_d    = e_end && !rstb_q ? ecyc_q + 1'b1 : ecyc_q;
        rstb_d    = rstb_q || (e_end && ecyc_d == 8'(RST_CYCLES));
    end
    always_ff @(posedge hsclk or posedge rst) begin
        if (rst) begin
            quarter_q <= '0;
            phase_q   <= 2'd0;
            wait_q    <= 3'd0;
            ecyc_q    <= 8'd0;
            eclk_q    <= 1'b0;
            qclk_q    <= 1'b0;
            stretch_q <= 1'b0;
            rstb_q    <= 1'b0;
        end else begin
            quarter_q <= quarter_d;
            phase_q   <= phase_d;
            wait_q    <= wait_d;
            ecyc_q    <= ecyc_d;
            eclk_q    <= phase_d[1];
            qclk_q    <= phase_d[1] ^ phase_d[0];
            stretch_q <= stretch_d;
            rstb_q    <= rstb_d;
        end
    end
    assign eclk       = eclk_q;
    assign qclk       = qclk_q;
    assign phase      = phase_q;
    assign stretching = stretch_q;
    assign cpu_rst_b  = rstb_q;
endmodule

// File: tb/tb_m6809e_clkgen.sv
// tb_m6809e_clkgen: checks a DIV=4 and a DIV=1 instance against a cycle-position model of the E clock.
module tb_m6809e_clkgen;
    logic hsclk = 1'b0, rst = 1'b1, csio_b = 1'b1;
    logic e0, q0, s0, rb0, e1, q1, s1, rb1;
    logic [1:0] p0, p1;
    int total = 0, bad = 0, ecnt = 0;
    int m_t[2], m_len[2], m_cnt[2];
    bit m_rb[2];

    always #5 hsclk = ~hsclk;

    m6809e_clkgen #(.DIV(4), .IO_WAIT(2), .RST_CYCLES(8)) u0 (
        .hsclk(hsclk), .rst(rst), .csio_b(csio_b), .eclk(e0), .qclk(q0),
        .phase(p0), .stretching(s0), .cpu_rst_b(rb0));
    m6809e_clkgen #(.DIV(1), .IO_WAIT(0), .RST_CYCLES(2)) u1 (
        .hsclk(hsclk), .rst(rst), .csio_b(csio_b), .eclk(e1), .qclk(q1),
        .phase(p1), .stretching(s1), .cpu_rst_b(rb1));

    function automatic int dv(int k); return k ? 1 : 4; endfunction
    function automatic int iw(int k); return k ? 0 : 2; endfunction
    function automatic int rc(int k); return k ? 2 : 8; endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge hsclk or posedge rst)
        if (rst) ecnt <= 0;
        else ecnt <= ecnt + 1;

    // Model: position within the current E cycle; the cycle length is fixed when E rises.
    always @(posedge hsclk or posedge rst)
        for (int k = 0; k < 2; k++)
            if (rst) begin
                m_t[k] <= 0; m_len[k] <= 4 * dv(k); m_cnt[k] <= 0; m_rb[k] <= 1'b0;
            end else begin
                if (m_t[k] + 1 == 2 * dv(k))
                    m_len[k] <= (!csio_b && m_rb[k]) ? (4 + iw(k)) * dv(k) : 4 * dv(k);
                if (m_t[k] + 1 == m_len[k]) begin
                    m_t[k] <= 0;
                    if (!m_rb[k]) begin
                        m_cnt[k] <= m_cnt[k] + 1;
                        if (m_cnt[k] + 1 == rc(k)) m_rb[k] <= 1'b1;
                    end
                end else m_t[k] <= m_t[k] + 1;
            end

    always @(negedge hsclk)
        if (!rst)
            for (int k = 0; k < 2; k++) begin
                int qi;
                qi = m_t[k] / dv(k);
                chk(k ? "u1 eclk" : "u0 eclk", k ? e1 : e0, qi >= 2);
                chk(k ? "u1 qclk" : "u0 qclk", k ? q1 : q0, qi == 1 || qi == 2);
                chk(k ? "u1 phase" : "u0 phase", k ? p1 : p0, qi > 3 ? 3 : qi);
                chk(k ? "u1 stretching" : "u0 stretching", k ? s1 : s0, qi >= 4);
                chk(k ? "u1 cpu_rst_b" : "u0 cpu_rst_b", k ? rb1 : rb0, m_rb[k]);
            end

    task automatic at_edge(int k);
        while (ecnt < k) @(negedge hsclk);
    endtask

    task automatic release_checks();
        csio_b = 1'b1;
        @(negedge hsclk); #1 rst = 1'b0;
        at_edge(1);  chk("u1 qclk rise@1", q1, 1); chk("u1 eclk@1", e1, 0);
        at_edge(2);  chk("u1 eclk rise@2", e1, 1);
        at_edge(3);  chk("u0 qclk@3", q0, 0);
        at_edge(4);  chk("u0 qclk rise@4", q0, 1); chk("u1 eclk fall@4", e1, 0);
        at_edge(7);  chk("u0 eclk@7", e0, 0);
        at_edge(8);  chk("u0 eclk rise@8", e0, 1); chk("u0 phase@8", p0, 2);
        at_edge(12); chk("u0 qclk fall@12", q0, 0); chk("u0 phase@12", p0, 3);
        at_edge(16); chk("u0 eclk fall@16", e0, 0); chk("u0 phase@16", p0, 0);
        while (ecnt < 127) begin @(negedge hsclk); csio_b = 1'($urandom); end
        chk("u0 cpu_rst_b@127", rb0, 0);
        at_edge(128); chk("u0 cpu_rst_b@128", rb0, 1); chk("u0 eclk fall@128", e0, 0);
    endtask

    task automatic meas(input bit c, output int hi, output int st, output int per);
        int n;
        n = 0; hi = 0; st = 0;
        while (p0 != 2'd1 && n < 400) begin @(negedge hsclk); n++; end
        csio_b = c;
        while (!e0 && n < 400) begin @(negedge hsclk); n++; end
        csio_b = 1'b1;
        while (e0 && n < 400) begin hi++; if (s0) st++; @(negedge hsclk); n++; end
        per = hi;
        while (!e0 && n < 400) begin per++; @(negedge hsclk); n++; end
        if (n >= 400) chk("meas timeout", n, 0);
    endtask

    initial begin
        int hi, st, per, n;
        repeat (3) @(negedge hsclk);
        chk("rst phase", p0, 0); chk("rst eclk", e0, 0); chk("rst qclk", q0, 0);
        chk("rst stretching", s0, 0); chk("rst cpu_rst_b", rb0, 0);
        release_checks();
        meas(1'b0, hi, st, per);
        chk("stretch E high", hi, 16); chk("stretch count", st, 8); chk("stretch period", per, 24);
        meas(1'b1, hi, st, per);
        chk("normal E high", hi, 8); chk("normal stretch", st, 0); chk("normal period", per, 16);
        repeat (2000) begin @(negedge hsclk); csio_b = 1'($urandom); end
        csio_b = 1'b0;
        n = 0;
        while (!s0 && n < 200) begin @(negedge hsclk); n++; end
        chk("reach stretch", s0, 1);
        #1 rst = 1'b1;
        #1;
        chk("async eclk", e0, 0); chk("async qclk", q0, 0);
        chk("async stretching", s0, 0); chk("async cpu_rst_b", rb0, 0);
        chk("async u1 eclk", e1, 0); chk("async phase", p0, 0);
        repeat (3) @(negedge hsclk);
        release_checks();
        repeat (500) begin @(negedge hsclk); csio_b = 1'($urandom); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
